tag_fifo: RTL and testbench
===========================

# tag_fifo

Free-list of ROB tags feeding the dispatch stage and the ROB allocate port. Holds every tag not currently owned by an in-flight instruction; hands the head tag to dispatch as `new_rd_tag`/`new_rd_tag_valid` and takes tags back when the ROB retires an entry. Circular buffer with read/write pointers and an occupancy counter; recovers to the all-free state on flush.

## Interface
- `TAG_W`, 5, tag width in bits.
- `DEPTH`, 32, number of tags; must equal 2**`TAG_W` (ROB depth).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Dispatch_tag_req`  in  1  dispatch consumes the head tag this cycle (pop).
- `Retire_valid`  in  1  ROB retires an entry this cycle (push).
- `Retire_rd_tag`  in  `TAG_W`  tag being returned.
- `Flush`  in  1  synchronous recovery: every tag returns to free.
- `new_rd_tag`  out  `TAG_W`  head-of-list tag, valid when `new_rd_tag_valid`=1.
- `new_rd_tag_valid`  out  1  list non-empty.
- `Tag_count`  out  `TAG_W`+1  number of free tags, 0..`DEPTH`.
- `Tag_overflow`  out  1  sticky error: push dropped because list was full.

## Operation
- Storage `mem[0..DEPTH-1]` of `TAG_W` bits; `rd_ptr`, `wr_ptr` `TAG_W` bits each; `count` `TAG_W`+1 bits.
- Reset (`reset`=0, async): `mem[i]`=i, `rd_ptr`=0, `wr_ptr`=0, `count`=`DEPTH`, `Tag_overflow`=0. Outputs after reset: `new_rd_tag`=0, `new_rd_tag_valid`=1, `Tag_count`=32, `Tag_overflow`=0.
- Pop accepted when `Dispatch_tag_req`=1 and `count`>0: `rd_ptr`+=1 (mod `DEPTH`). Pop with `count`=0 is ignored (no state change, no error).
- Push accepted when `Retire_valid`=1 and (`count`<`DEPTH` or pop accepted same cycle): `mem[wr_ptr]`=`Retire_rd_tag`, `wr_ptr`+=1 (mod `DEPTH`).
- Push with `count`=`DEPTH` and no accepted pop: dropped; `Tag_overflow` set, held until reset or `Flush`.
- `count` next = `count` + push_acc − pop_acc.
- Simultaneous push+pop, 0<`count`<`DEPTH`: both occur, `count` unchanged.
- Push+pop with `count`=0: no bypass; pop ignored, push accepted, `count`=1; returned tag is visible at head next cycle.
- Push+pop with `count`=`DEPTH`: both accepted, no overflow.
- `Flush`=1 overrides push/pop: same state as reset (mem re-initialised to identity, pointers 0, `count`=`DEPTH`, `Tag_overflow` cleared).
- No duplicate-tag checking; the ROB guarantees each tag is returned exactly once.

## Timing
- `new_rd_tag` = `mem[rd_ptr]`, `new_rd_tag_valid` = (`count`!=0), `Tag_count` = `count`: all combinational from registers, stable the whole cycle.
- Dispatch samples `new_rd_tag` and asserts `Dispatch_tag_req` in the same cycle; the next tag appears after the rising edge.
- Returned tag reusable at the earliest one cycle after its push edge.
- `Flush` takes effect at the rising edge where it is high; outputs show full state the following cycle.
- Reset asserted mid-operation clears state immediately, independent of `clock`.

## Structure
- Shared package `rob_pkg`: `TAG_W`, `ROB_DEPTH`, `tag_t` (`TAG_W`-bit), `count_t` (`TAG_W`+1-bit); ROB, dispatch and this block import it.
- Single module, no sub-modules; pointers and storage are flat registers (identity init needs per-entry reset, so no RAM macro).

## Test plan
- Reset, then 32 back-to-back pops -> tags 0,1,...,31 in order; after the 32nd, `new_rd_tag_valid`=0, `Tag_count`=0; 33rd pop -> no change.
- Empty list, push tag 7 with pop same cycle -> `Tag_count`=1, next cycle `new_rd_tag`=7; pop -> `Tag_count`=0.
- Pop 4 (tags 0-3), push 2 then 0, then 28 pops -> tags 4..31 then 2, 0; verifies wrap of `wr_ptr`/`rd_ptr` past 31.
- Full list, push tag 5 without pop -> `Tag_overflow`=1, `Tag_count` stays 32; push+pop on full list -> no overflow, count 32.
- After 10 pops and 3 pushes assert `Flush` one cycle -> `Tag_count`=32, `new_rd_tag`=0, `Tag_overflow`=0, next 32 pops yield 0..31.
- Drop `reset` low between clock edges mid-stream -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB-side definitions: tag width, ROB depth and the tag/count types
// used by the ROB, dispatch and the tag free-list.
package rob_pkg;

  localparam int TAG_W     = 5;
  localparam int ROB_DEPTH = 1 << TAG_W;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   count_t;

endpackage : rob_pkg

// File: rtl/tag_fifo.sv
// Free-list of ROB tags: circular buffer whose head feeds dispatch and whose
// tail is refilled by ROB retirement. Reset and Flush restore the identity list.
module tag_fifo #(
  parameter int TAG_W = rob_pkg::TAG_W,
  parameter int DEPTH = rob_pkg::ROB_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Dispatch_tag_req,
  input  logic             Retire_valid,
  input  logic [TAG_W-1:0] Retire_rd_tag,
  input  logic             Flush,
  output logic [TAG_W-1:0] new_rd_tag,
  output logic             new_rd_tag_valid,
  output logic [TAG_W:0]   Tag_count,
  output logic             Tag_overflow
);

  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [TAG_W-1:0] r_rdPtr;
  logic [TAG_W-1:0] r_wrPtr;
  logic [TAG_W:0]   r_count;
  logic             r_overflow;

  logic w_popAcc;
  logic w_pushAcc;
  logic w_pushDrop;

  // A full list can still take a push when the head leaves in the same cycle.
  assign w_popAcc   = Dispatch_tag_req && (r_count != '0);
  assign w_pushAcc  = Retire_valid && ((r_count != CNT_FULL) || w_popAcc);
  assign w_pushDrop = Retire_valid && !w_pushAcc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= TAG_W'(i);
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= CNT_FULL;
      r_overflow <= 1'b0;
    end else if (Flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= TAG_W'(i);
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= CNT_FULL;
      r_overflow <= 1'b0;
    end else begin
      if (w_popAcc) r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_pushAcc) begin
        r_mem[r_wrPtr] <= Retire_rd_tag;
        r_wrPtr        <= r_wrPtr + PTR_ONE;
      end
      if (w_pushAcc && !w_popAcc)      r_count <= r_count + CNT_ONE;
      else if (!w_pushAcc && w_popAcc) r_count <= r_count - CNT_ONE;
      if (w_pushDrop) r_overflow <= 1'b1;
    end
  end

  assign new_rd_tag       = r_mem[r_rdPtr];
  assign new_rd_tag_valid = (r_count != '0);
  assign Tag_count        = r_count;
  assign Tag_overflow     = r_overflow;

endmodule : tag_fifo

// File: tb/tb_tag_fifo.sv
// Directed bench for tag_fifo: drain/refill ordering, pointer wrap, overflow,
// Flush recovery and asynchronous reset, with hand-computed expectations.
module tb_tag_fifo;

  logic       clock;
  logic       reset;
  logic       Dispatch_tag_req;
  logic       Retire_valid;
  logic [4:0] Retire_rd_tag;
  logic       Flush;
  logic [4:0] new_rd_tag;
  logic       new_rd_tag_valid;
  logic [5:0] Tag_count;
  logic       Tag_overflow;

  int nCompared = 0;
  int nMismatched = 0;

  tag_fifo #(.TAG_W(5), .DEPTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .Dispatch_tag_req (Dispatch_tag_req),
    .Retire_valid     (Retire_valid),
    .Retire_rd_tag    (Retire_rd_tag),
    .Flush            (Flush),
    .new_rd_tag       (new_rd_tag),
    .new_rd_tag_valid (new_rd_tag_valid),
    .Tag_count        (Tag_count),
    .Tag_overflow     (Tag_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic applyStimulus(input logic req, input logic rv,
                               input logic [4:0] rtag, input logic fl);
    Dispatch_tag_req = req;
    Retire_valid     = rv;
    Retire_rd_tag    = rtag;
    Flush            = fl;
    @(posedge clock);
    #1;
    Dispatch_tag_req = 1'b0;
    Retire_valid     = 1'b0;
    Retire_rd_tag    = '0;
    Flush            = 1'b0;
  endtask

  task automatic checkState(input string tag, input int expTag, input int expValid,
                            input int expCount, input int expOvf);
    if (expValid != 0) checkOutput({tag, "_tag"}, 32'(new_rd_tag), 32'(expTag));
    checkOutput({tag, "_valid"}, 32'(new_rd_tag_valid), 32'(expValid));
    checkOutput({tag, "_count"}, 32'(Tag_count), 32'(expCount));
    checkOutput({tag, "_ovf"}, 32'(Tag_overflow), 32'(expOvf));
  endtask

  initial begin
    reset            = 1'b0;
    Dispatch_tag_req = 1'b0;
    Retire_valid     = 1'b0;
    Retire_rd_tag    = '0;
    Flush            = 1'b0;
    #12 reset = 1'b1;
    @(posedge clock);
    #1;
    checkState("reset", 0, 1, 32, 0);

    // 32 pops yield 0..31, then empty; a 33rd pop changes nothing.
    for (int i = 0; i < 32; i++) begin
      checkOutput("drain_tag", 32'(new_rd_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    end
    checkState("drained", 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("pop_empty", 0, 0, 0, 0);

    // Push+pop on empty: no bypass, tag 7 becomes the head.
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0);
    checkState("empty_pushpop", 7, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("pop_7", 0, 0, 0, 0);

    // Pointer wrap: pop 0-3, return 2 and 0, drain 4..31 then 2, 0.
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
    checkState("flush1", 0, 1, 32, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("pop4", 4, 1, 28, 0);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b0);
    checkState("push2", 4, 1, 30, 0);
    for (int i = 4; i < 32; i++) begin
      checkOutput("wrap_tag", 32'(new_rd_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    end
    checkOutput("wrap_tag_a", 32'(new_rd_tag), 32'd2);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("wrap_tag_b", 32'(new_rd_tag), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("wrap_empty", 0, 0, 0, 0);

    // Full list: push+pop is legal, a lone push overflows and sticks.
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0);
    checkState("full_pushpop", 1, 1, 32, 0);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b0);
    checkState("full_push", 1, 1, 32, 1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkState("ovf_sticky", 1, 1, 32, 1);

    // Continue from rd=1, wr=1: 10 pops, 3 pushes, then Flush.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("pop10", 11, 1, 22, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 5'(20 + i), 1'b0);
    checkState("push3", 11, 1, 25, 1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
    checkState("flush2", 0, 1, 32, 0);
    for (int i = 0; i < 32; i++) begin
      checkOutput("flush_drain", 32'(new_rd_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    end
    checkState("flush_drained", 0, 0, 0, 0);

    // Asynchronous reset between edges restores the full list immediately.
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("pre_reset", 3, 1, 29, 1);
    #2 reset = 1'b0;
    #1;
    checkState("async_reset", 0, 1, 32, 0);
    #2 reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkState("post_reset_pop", 1, 1, 31, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_tag_fifo
